// File: rtl/tick_ctrl_if.sv
// Command port for tick_ctrl: valid/ready handshake carrying an opcode and a step count.
interface tick_ctrl_if #(
    parameter int STEP_W = 16
);
    logic              cmd_valid;
    logic [2:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic              cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/tick_ctrl.sv
// Turns rising edges of the divided tick clock into one-cycle tick enables for the
// redstone core, with run/pause/single-step control and tick/overrun counters.
module tick_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int STEP_W      = 16,
    parameter int OVR_W       = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tick_src,
    input  logic             sim_busy,
    tick_ctrl_if.slave       cmd,
    output logic             tick_en,
    output logic             running,
    output logic [CNT_W-1:0] tick_count,
    output logic [OVR_W-1:0] overrun_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [2:0] OP_RUN   = 3'd1;
    localparam logic [2:0] OP_PAUSE = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [OVR_W-1:0]  OVR_ONE  = 1;
    localparam logic [STEP_W-1:0] STEP_ONE = 1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   tick_en_q, tick_en_d;
    logic                   running_q, running_d;
    logic                   ready_q, ready_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [OVR_W-1:0]       ovr_q, ovr_d;
    logic [STEP_W-1:0]      rem_q, rem_d;

    logic                   edge_req;
    logic                   accept;
    logic [2:0]             cmd_op;
    logic [STEP_W-1:0]      cmd_arg;

    assign cmd_op   = cmd.cmd_op;
    assign cmd_arg  = cmd.cmd_arg;
    assign accept   = cmd.cmd_valid & ready_q;
    assign edge_req = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], tick_src};
        prev_d    = sync_q[SYNC_STAGES-1];
        ready_d   = ~accept;
        state_d   = state_q;
        rem_d     = rem_q;
        tick_en_d = 1'b0;
        count_d   = count_q;
        ovr_d     = ovr_q;

        // The tick decision is made from the pre-command state; a command accepted
        // in the same cycle then overrides next state, remaining and counters.
        if (edge_req && state_q != ST_IDLE) begin
            if (sim_busy) begin
                ovr_d = (ovr_q == '1) ? ovr_q : ovr_q + OVR_ONE;
            end else begin
                tick_en_d = 1'b1;
                count_d   = count_q + CNT_ONE;
                if (state_q == ST_STEP && rem_q != '0) begin
                    rem_d = rem_q - STEP_ONE;
                    if (rem_q == STEP_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        end

        if (accept) begin
            case (cmd_op)
                OP_RUN:   state_d = ST_RUN;
                OP_PAUSE: state_d = ST_IDLE;
                OP_STEP: begin
                    if (cmd_arg != '0) begin
                        state_d = ST_STEP;
                        rem_d   = cmd_arg;
                    end
                end
                OP_CLEAR: begin
                    count_d = '0;
                    ovr_d   = '0;
                end
                default: ;
            endcase
        end

        running_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            tick_en_q <= 1'b0;
            running_q <= 1'b0;
            ready_q   <= 1'b0;
            count_q   <= '0;
            ovr_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            tick_en_q <= tick_en_d;
            running_q <= running_d;
            ready_q   <= ready_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            rem_q     <= rem_d;
        end
    end

    assign cmd.cmd_ready  = ready_q;
    assign tick_en        = tick_en_q;
    assign running        = running_q;
    assign tick_count     = count_q;
    assign overrun_count  = ovr_q;

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl: a table of command/edge-burst rows plus hand-written
// sequences for latency, same-cycle command/tick interaction, handshake and reset.
module tb_tick_ctrl;

    localparam int CNT_W  = 4;
    localparam int STEP_W = 16;
    localparam int OVR_W  = 8;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_RUN   = 3'd1;
    localparam logic [2:0] OP_PAUSE = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             tick_src;
    logic             sim_busy;
    logic             tick_en;
    logic             running;
    logic [CNT_W-1:0] tick_count;
    logic [OVR_W-1:0] overrun_count;

    int assertCount = 0;
    int failCount   = 0;
    int pulseCount  = 0;

    typedef struct {
        logic [2:0]        op;
        logic [STEP_W-1:0] arg;
        logic              busy;
        int                edges;
        int                half;
        int                pulses;
        logic [CNT_W-1:0]  count;
        logic [OVR_W-1:0]  ovr;
        logic              run;
    } vec_t;

    vec_t vecs[11];

    tick_ctrl_if #(.STEP_W(STEP_W)) cmdBus();

    tick_ctrl #(
        .SYNC_STAGES(2),
        .CNT_W(CNT_W),
        .STEP_W(STEP_W),
        .OVR_W(OVR_W)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .tick_src(tick_src),
        .sim_busy(sim_busy),
        .cmd(cmdBus.slave),
        .tick_en(tick_en),
        .running(running),
        .tick_count(tick_count),
        .overrun_count(overrun_count)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (tick_en === 1'b1) pulseCount++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic sendCmd(input logic [2:0] op, input logic [STEP_W-1:0] arg);
        int waitCycles;
        waitCycles = 0;
        while (cmdBus.cmd_ready !== 1'b1 && waitCycles < 20) begin
            step();
            waitCycles++;
        end
        if (cmdBus.cmd_ready !== 1'b1) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL cmd_ready_timeout: got %b, expected 1", cmdBus.cmd_ready);
        end else begin
            cmdBus.cmd_valid = 1'b1;
            cmdBus.cmd_op    = op;
            cmdBus.cmd_arg   = arg;
            step();
            cmdBus.cmd_valid = 1'b0;
            cmdBus.cmd_op    = OP_NOP;
            cmdBus.cmd_arg   = '0;
        end
    endtask

    task automatic genEdges(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            tick_src = 1'b1;
            repeat (half) step();
            tick_src = 1'b0;
            repeat (half) step();
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int p0;
        sendCmd(v.op, v.arg);
        sim_busy = v.busy;
        p0 = pulseCount;
        genEdges(v.edges, v.half);
        repeat (6) step();
        checkOutput($sformatf("row%0d_pulses", idx), 32'(pulseCount - p0), 32'(v.pulses));
        checkOutput($sformatf("row%0d_count", idx), 32'(tick_count), 32'(v.count));
        checkOutput($sformatf("row%0d_overrun", idx), 32'(overrun_count), 32'(v.ovr));
        checkOutput($sformatf("row%0d_running", idx), 32'(running), 32'(v.run));
        sim_busy = 1'b0;
    endtask

    initial begin
        int p0;

        vecs[0]  = '{OP_RUN,   16'd0, 1'b0,   5, 10,  5, 4'd5, 8'd0,   1'b1};
        vecs[1]  = '{OP_PAUSE, 16'd0, 1'b0,   2, 10,  0, 4'd5, 8'd0,   1'b0};
        vecs[2]  = '{OP_CLEAR, 16'd0, 1'b0,   0, 10,  0, 4'd0, 8'd0,   1'b0};
        vecs[3]  = '{OP_STEP,  16'd3, 1'b0,   6, 10,  3, 4'd3, 8'd0,   1'b0};
        vecs[4]  = '{OP_STEP,  16'd0, 1'b0,   2, 10,  0, 4'd3, 8'd0,   1'b0};
        vecs[5]  = '{OP_RUN,   16'd0, 1'b1, 300,  4,  0, 4'd3, 8'd255, 1'b1};
        vecs[6]  = '{OP_CLEAR, 16'd0, 1'b0,   0,  4,  0, 4'd0, 8'd0,   1'b1};
        vecs[7]  = '{OP_RUN,   16'd0, 1'b0,  17,  4, 17, 4'd1, 8'd0,   1'b1};
        vecs[8]  = '{3'd7,     16'd9, 1'b0,   1,  4,  1, 4'd2, 8'd0,   1'b1};
        vecs[9]  = '{OP_STEP,  16'd4, 1'b1,   2,  4,  0, 4'd2, 8'd2,   1'b1};
        vecs[10] = '{OP_NOP,   16'd0, 1'b0,   4,  4,  4, 4'd6, 8'd2,   1'b0};

        rst              = 1'b1;
        tick_src         = 1'b0;
        sim_busy         = 1'b0;
        cmdBus.cmd_valid = 1'b0;
        cmdBus.cmd_op    = OP_NOP;
        cmdBus.cmd_arg   = '0;
        repeat (3) step();
        checkOutput("reset_tick_en", 32'(tick_en), 32'd0);
        checkOutput("reset_running", 32'(running), 32'd0);
        checkOutput("reset_count", 32'(tick_count), 32'd0);
        checkOutput("reset_overrun", 32'(overrun_count), 32'd0);
        checkOutput("reset_ready", 32'(cmdBus.cmd_ready), 32'd0);
        rst = 1'b0;
        step();
        checkOutput("post_reset_ready", 32'(cmdBus.cmd_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Counter wrap: count read back after every single edge.
        sendCmd(OP_RUN, '0);
        sendCmd(OP_CLEAR, '0);
        step();
        for (int i = 1; i <= 17; i++) begin
            genEdges(1, 4);
            checkOutput($sformatf("wrap_count_%0d", i), 32'(tick_count), 32'(i % 16));
        end

        // Synchroniser latency: pulse appears after the third clock edge only.
        repeat (3) step();
        tick_src = 1'b1;
        step();
        checkOutput("latency_edge1", 32'(tick_en), 32'd0);
        step();
        checkOutput("latency_edge2", 32'(tick_en), 32'd0);
        step();
        checkOutput("latency_edge3", 32'(tick_en), 32'd1);
        step();
        checkOutput("latency_edge4", 32'(tick_en), 32'd0);
        tick_src = 1'b0;
        repeat (6) step();

        // PAUSE accepted in the very cycle the edge is detected.
        tick_src = 1'b1;
        step();
        step();
        cmdBus.cmd_valid = 1'b1;
        cmdBus.cmd_op    = OP_PAUSE;
        step();
        cmdBus.cmd_valid = 1'b0;
        cmdBus.cmd_op    = OP_NOP;
        checkOutput("pause_same_cycle_tick", 32'(tick_en), 32'd1);
        checkOutput("pause_same_cycle_running", 32'(running), 32'd0);
        tick_src = 1'b0;
        repeat (4) step();
        p0 = pulseCount;
        genEdges(1, 10);
        repeat (6) step();
        checkOutput("after_pause_pulses", 32'(pulseCount - p0), 32'd0);

        // CLEAR arriving alongside a tick: clear wins.
        sendCmd(OP_RUN, '0);
        genEdges(2, 10);
        repeat (6) step();
        tick_src = 1'b1;
        step();
        step();
        cmdBus.cmd_valid = 1'b1;
        cmdBus.cmd_op    = OP_CLEAR;
        step();
        cmdBus.cmd_valid = 1'b0;
        cmdBus.cmd_op    = OP_NOP;
        checkOutput("clear_with_tick_en", 32'(tick_en), 32'd1);
        checkOutput("clear_with_tick_count", 32'(tick_count), 32'd0);
        tick_src = 1'b0;
        repeat (6) step();

        // Back-to-back commands: only alternate ones are taken.
        sendCmd(OP_PAUSE, '0);
        repeat (3) step();
        checkOutput("b2b_ready0", 32'(cmdBus.cmd_ready), 32'd1);
        cmdBus.cmd_valid = 1'b1;
        cmdBus.cmd_op    = OP_RUN;
        step();
        checkOutput("b2b_ready1", 32'(cmdBus.cmd_ready), 32'd0);
        cmdBus.cmd_op    = OP_PAUSE;
        step();
        checkOutput("b2b_ready2", 32'(cmdBus.cmd_ready), 32'd1);
        cmdBus.cmd_op    = OP_NOP;
        step();
        checkOutput("b2b_ready3", 32'(cmdBus.cmd_ready), 32'd0);
        cmdBus.cmd_op    = OP_PAUSE;
        step();
        cmdBus.cmd_valid = 1'b0;
        cmdBus.cmd_op    = OP_NOP;
        step();
        checkOutput("b2b_running", 32'(running), 32'd1);

        // Reset in the middle of a STEP sequence.
        sendCmd(OP_PAUSE, '0);
        sendCmd(OP_STEP, 16'd5);
        repeat (3) step();
        checkOutput("mid_step_running", 32'(running), 32'd1);
        rst = 1'b1;
        step();
        step();
        checkOutput("rst_mid_tick_en", 32'(tick_en), 32'd0);
        checkOutput("rst_mid_running", 32'(running), 32'd0);
        checkOutput("rst_mid_count", 32'(tick_count), 32'd0);
        checkOutput("rst_mid_overrun", 32'(overrun_count), 32'd0);
        checkOutput("rst_mid_ready", 32'(cmdBus.cmd_ready), 32'd0);
        rst = 1'b0;
        step();
        p0 = pulseCount;
        genEdges(2, 10);
        repeat (6) step();
        checkOutput("after_rst_pulses", 32'(pulseCount - p0), 32'd0);
        checkOutput("after_rst_running", 32'(running), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
